// File: rtl/gaussian_window_feeder.sv
// Streams a raster image through two line buffers and a 3x3 shift window,
// emitting one window per interior pixel with valid/ready handshaking.
module gaussian_window_feeder #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int PIX_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PIX_W-1:0]   in_pixel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [9*PIX_W-1:0] win_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  logic [CW-1:0]    col_p0;
  logic [RW-1:0]    row_p0;
  logic [PIX_W-1:0] lb1 [IMG_WIDTH];
  logic [PIX_W-1:0] lb2 [IMG_WIDTH];
  logic [PIX_W-1:0] lb1_rd_p0;
  logic [PIX_W-1:0] lb2_rd_p0;
  logic             accept_p0;
  logic             col_end_p0;
  logic             row_end_p0;
  logic             emit_p0;

  logic [PIX_W-1:0] win_p1 [3][3];
  logic             vld_p1;
  logic             last_p1;
  logic             done_p1;

  // Stage p0: acceptance, raster position and line-buffer read
  assign in_ready   = !vld_p1 || out_ready;
  assign accept_p0  = in_valid && in_ready;
  assign col_end_p0 = (col_p0 == CW'(IMG_WIDTH - 1));
  assign row_end_p0 = (row_p0 == RW'(IMG_HEIGHT - 1));
  assign emit_p0    = (row_p0 >= RW'(2)) && (col_p0 >= CW'(2));
  assign lb1_rd_p0  = lb1[col_p0];
  assign lb2_rd_p0  = lb2[col_p0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_p0 <= '0;
      row_p0 <= '0;
    end else if (accept_p0) begin
      if (col_end_p0) begin
        col_p0 <= '0;
        row_p0 <= row_end_p0 ? '0 : row_p0 + RW'(1);
      end else begin
        col_p0 <= col_p0 + CW'(1);
      end
    end
  end

  // Line buffers are never cleared; rows 0 and 1 of each frame overwrite them first.
  always_ff @(posedge clk) begin
    if (accept_p0) begin
      lb2[col_p0] <= lb1_rd_p0;
      lb1[col_p0] <= in_pixel;
    end
  end

  // Stage p1: shift window and output handshake state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          win_p1[i][j] <= '0;
    end else if (accept_p0) begin
      for (int i = 0; i < 3; i++) begin
        win_p1[i][0] <= win_p1[i][1];
        win_p1[i][1] <= win_p1[i][2];
      end
      win_p1[0][2] <= lb2_rd_p0;
      win_p1[1][2] <= lb1_rd_p0;
      win_p1[2][2] <= in_pixel;
    end
  end

  // Acceptance while valid implies out_ready, so a held window is never overwritten.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      done_p1 <= 1'b0;
    end else begin
      done_p1 <= accept_p0 && row_end_p0 && col_end_p0;
      if (accept_p0) begin
        vld_p1  <= emit_p0;
        last_p1 <= emit_p0 && row_end_p0 && col_end_p0;
      end else if (out_ready) begin
        vld_p1  <= 1'b0;
        last_p1 <= 1'b0;
      end
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_row
    for (genvar gj = 0; gj < 3; gj++) begin : g_col
      assign win_data[PIX_W*(3*gi+gj) +: PIX_W] = win_p1[gi][gj];
    end
  end

  assign out_valid  = vld_p1;
  assign out_last   = last_p1;
  assign frame_done = done_p1;

endmodule

// File: tb/tb_gaussian_window_feeder.sv
// Directed bench for gaussian_window_feeder on a 4x4 image with 8-bit pixels.
module tb_gaussian_window_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_pixel;
  logic        in_valid;
  logic        in_ready;
  logic [71:0] win_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  gaussian_window_feeder #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .PIX_W(8)) dut (
    .clk(clk), .reset(reset), .in_pixel(in_pixel), .in_valid(in_valid),
    .in_ready(in_ready), .win_data(win_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [71:0] pack9(input int t0, t1, t2, t3, t4, t5, t6, t7, t8);
    return {8'(t8), 8'(t7), 8'(t6), 8'(t5), 8'(t4), 8'(t3), 8'(t2), 8'(t1), 8'(t0)};
  endfunction

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_pixel = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({out_valid, out_last, frame_done, in_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_ctrl got v/l/d/rdy=%b exp 0001", {out_valid, out_last, frame_done, in_ready});
    end
    checks++;
    if (win_data !== 72'h0) begin
      errors++;
      $display("FAIL reset_win got %h exp 0", win_data);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_rdy_after got %b exp 1", in_ready);
    end
  endtask

  // Full frame with out_ready held high; pixel values base+1 .. base+16.
  task automatic test_frame(input int base, input string tag);
    int nwin = 0;
    int ndone = 0;
    logic [71:0] exp;
    logic exp_v, exp_l;
    out_ready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        in_pixel = 8'(base + r*4 + c + 1);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        exp_v = (r >= 2) && (c >= 2);
        exp_l = (r == 3) && (c == 3);
        if (out_valid) nwin++;
        if (frame_done) ndone++;
        checks++;
        if (out_valid !== exp_v) begin
          errors++;
          $display("FAIL %s_valid r%0d c%0d got %b exp %b", tag, r, c, out_valid, exp_v);
        end
        if (exp_v) begin
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              exp[8*(3*i+j) +: 8] = 8'(base + (r-2+i)*4 + (c-2+j) + 1);
          checks++;
          if (win_data !== exp) begin
            errors++;
            $display("FAIL %s_win r%0d c%0d got %h exp %h", tag, r, c, win_data, exp);
          end
          checks++;
          if (out_last !== exp_l) begin
            errors++;
            $display("FAIL %s_last r%0d c%0d got %b exp %b", tag, r, c, out_last, exp_l);
          end
        end
        checks++;
        if (frame_done !== exp_l) begin
          errors++;
          $display("FAIL %s_done r%0d c%0d got %b exp %b", tag, r, c, frame_done, exp_l);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (nwin !== 4 || ndone !== 1) begin
      errors++;
      $display("FAIL %s_count windows %0d done %0d exp 4 1", tag, nwin, ndone);
    end
  endtask

  task automatic test_idle_drain();
    out_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, out_last, frame_done} !== 3'b000) begin
      errors++;
      $display("FAIL drain got v/l/d=%b exp 000", {out_valid, out_last, frame_done});
    end
  endtask

  task automatic test_stall();
    logic [71:0] first;
    first = pack9(1, 2, 3, 5, 6, 7, 9, 10, 11);
    out_ready = 1'b0;
    for (int k = 0; k < 11; k++) begin
      in_pixel = 8'(k + 1); in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (out_valid !== 1'b1 || win_data !== first) begin
      errors++;
      $display("FAIL stall_first got v=%b %h exp 1 %h", out_valid, win_data, first);
    end
    in_pixel = 8'd12;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || win_data !== first) begin
        errors++;
        $display("FAIL stall_hold cyc%0d got rdy=%b v=%b %h exp 0 1 %h", k, in_ready, out_valid, win_data, first);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || win_data !== pack9(2, 3, 4, 6, 7, 8, 10, 11, 12)) begin
      errors++;
      $display("FAIL stall_resume got v=%b %h exp 1 %h", out_valid, win_data, pack9(2, 3, 4, 6, 7, 8, 10, 11, 12));
    end
    for (int k = 13; k <= 16; k++) begin
      in_pixel = 8'(k);
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== (k >= 15)) begin
        errors++;
        $display("FAIL stall_tail_valid px%0d got %b exp %b", k, out_valid, (k >= 15));
      end
    end
    checks++;
    if (win_data !== pack9(6, 7, 8, 10, 11, 12, 14, 15, 16) || out_last !== 1'b1 || frame_done !== 1'b1) begin
      errors++;
      $display("FAIL stall_last got %h l=%b d=%b exp %h 1 1", win_data, out_last, frame_done, pack9(6, 7, 8, 10, 11, 12, 14, 15, 16));
    end
    in_valid = 1'b0;
    test_idle_drain();
  endtask

  task automatic test_back_to_back();
    test_frame(0, "b2b_f1");
    test_frame(100, "b2b_f2");
    test_idle_drain();
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_pixel = 8'(200 + k); in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst got v=%b rdy=%b exp 0 1", out_valid, in_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    test_frame(0, "after_rst");
    test_idle_drain();
  endtask

  initial begin
    test_reset();
    test_frame(0, "basic");
    test_idle_drain();
    test_stall();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gaussian_window_feeder.md
GAUSSIAN_WINDOW_FEEDER -- requirements
Module: gaussian_window_feeder

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 320, pixels per row (>=3).
REQ-002 SHALL have parameter IMG_HEIGHT, default 240, rows per frame (>=3).
REQ-003 SHALL have parameter PIX_W, default 8, bits per pixel.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port in_pixel  input  PIX_W  raster-order pixel stream.
REQ-007 SHALL have port in_valid  input  1  in_pixel valid.
REQ-008 SHALL have port in_ready  output  1  block accepts pixel this cycle.
REQ-009 SHALL have port win_data  output  9*PIX_W  3x3 window; tap (i,j) at bits [PIX_W*(3i+j) +: PIX_W]; i = row (0 = oldest), j = column (0 = leftmost).
REQ-010 SHALL have port out_valid  output  1  win_data valid.
REQ-011 SHALL have port out_ready  input  1  downstream consumes window.
REQ-012 SHALL have port out_last  output  1  window is the last of the frame; qualified by out_valid.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse on acceptance of the final frame pixel.

Function
REQ-014 Pixel accepted iff in_valid && in_ready; no state changes on cycles without acceptance.
REQ-015 in_ready SHALL be combinational: !out_valid || out_ready.
REQ-016 Column counter col (0..IMG_WIDTH-1) and row counter row (0..IMG_HEIGHT-1) SHALL give the position of the next accepted pixel; col increments per acceptance; wraps to 0 with row+1; at (IMG_HEIGHT-1, IMG_WIDTH-1) both wrap to 0.
REQ-017 Two line buffers of IMG_WIDTH x PIX_W SHALL be kept: LB1 holds row-1, LB2 holds row-2. On acceptance at column c: LB2[c] <= LB1[c]; LB1[c] <= in_pixel.
REQ-018 A 3x3 shift window SHALL, on acceptance at column c, shift columns left and load the new right column as (LB2[c], LB1[c], in_pixel) for rows 0,1,2.
REQ-019 Window emission: acceptance of pixel (r,c) with r>=2 and c>=2 SHALL set out_valid=1 on the next cycle with tap (i,j) = pixel(r-2+i, c-2+j); windows are not emitted for r<2 or c<2 (no border padding).
REQ-020 Latency: one cycle from pixel acceptance to out_valid.
REQ-021 Windows per frame SHALL be (IMG_WIDTH-2)*(IMG_HEIGHT-2).
REQ-022 While out_valid=1 && out_ready=0, win_data, out_valid and out_last SHALL hold stable.
REQ-023 If out_valid && out_ready and a pixel is accepted in the same cycle: if it is window-producing, the new window is loaded (out_valid stays 1); otherwise out_valid clears.
REQ-024 If out_valid && out_ready with no acceptance, out_valid SHALL clear next cycle.
REQ-025 out_last SHALL be 1 exactly for the window produced by pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
REQ-026 frame_done SHALL pulse the cycle after accepting pixel (IMG_HEIGHT-1, IMG_WIDTH-1); next frame starts immediately at (0,0) with no idle cycle required.
REQ-027 Line buffer contents SHALL NOT be cleared between frames; stale data never reaches an emitted window per REQ-019.

Reset
REQ-028 On reset=1 asynchronously: col=0, row=0, out_valid=0, out_last=0, frame_done=0, win_data=0, shift window=0; line buffers not reset.
REQ-029 During and after reset with out_valid=0, in_ready SHALL be 1.
REQ-030 Reset mid-frame SHALL abandon the frame; the first pixel accepted after release is (0,0).

Verification
REQ-031 IMG_WIDTH=4, IMG_HEIGHT=4, PIX_W=8, pixels 1..16 raster, out_ready=1 -> exactly 4 windows; first (after pixel 11) rows {1,2,3},{5,6,7},{9,10,11}; last rows {6,7,8},{10,11,12},{14,15,16} with out_last=1; frame_done pulses once.
REQ-032 Same stream, out_ready=0 held 5 cycles after first out_valid -> in_ready=0, win_data stable at {1,2,3,5,6,7,9,10,11}; on out_ready=1 stream resumes with no pixel lost or duplicated.
REQ-033 Two back-to-back 4x4 frames (second frame values 101..116) -> 8 windows; second frame's first window {101,102,103,105,106,107,109,110,111}; no first-frame data leaks.
REQ-034 Assert reset after 6 pixels of a frame -> out_valid=0, counters 0; then a full 4x4 frame -> identical output to REQ-031.
REQ-035 Random in_valid/out_ready gaps, default parameters -> 75684 windows, each matching a reference 3x3 model; one out_last, one frame_done.
